uart_cfg_m: RTL and testbench
=============================

Name: uart_cfg_m

Overview:
Parametrised successor to the fixed 8N1 UART core. Full-duplex UART with compile-time data width (5..9), parity mode and stop-bit count, and 8x oversampled receive. Also provides receive parity/framing error flags, glitch-rejecting start detection and an internal loopback mode. Sits between the board-level pin SB_IO/metastability registers and user logic; pin inversion and synchronisation stay outside this block.

Parameters:
SYSCLKFRQ, 12000000, system clock frequency in Hz
BITCLKFRQ, 115200, bit rate in bps
ACCEPTEDERROR_IN_PERCENT, 2, max allowed bit-rate error; elaboration-time $error if exceeded
DATABITS, 8, data bits per frame, legal 5..9
PARITY, 0, 0=none, 1=even, 2=odd
STOPBITS, 1, stop bits transmitted, 1 or 2
HASRXBYTEREGISTER, 1, 1=q held in dedicated register; 0=q is rx shift register, valid only while bytercvd=1

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
load  input  1  request to transmit d; accepted only when txbusy=0
d  input  DATABITS  transmit data, sampled in the accepting cycle
txpin  output  1  serial out, logic level, idle 1
txbusy  output  1  transmitter active
rxpin  input  1  serial in, already synchronised, idle 1
loopback  input  1  1 = receiver takes txpin internally, rxpin ignored
bitx8ce  output  1  one-clk pulse at 8x bit rate
bytercvd  output  1  one-clk pulse: frame received
q  output  DATABITS  received data
parerr  output  1  parity error of last frame, valid with bytercvd
frmerr  output  1  framing error of last frame, valid with bytercvd

Behaviour:
- DIV = round(SYSCLKFRQ/(8*BITCLKFRQ)). Prescaler counts 0..DIV-1; bitx8ce=1 in the cycle it is DIV-1. Free-running; never restarted by frames.
- Reset values: txpin=1, txbusy=0, bitx8ce=0, bytercvd=0, q=0, parerr=0, frmerr=0. Prescaler=0, both FSMs idle. rst mid-frame abandons the frame; txpin=1 from the cycle after rst.
- TX FSM IDLE -> START -> DATA -> PARITY (only if PARITY!=0) -> STOP -> IDLE.
- load with txbusy=0: latch d; txbusy=1 next cycle. load while txbusy=1 is ignored, with no queuing.
- START begins at the first bitx8ce after acceptance. Each bit lasts 8 bitx8ce ticks. Data is sent LSB first. Parity bit = XOR(data) for even, inverted for odd. STOP lasts STOPBITS*8 ticks.
- txbusy falls in the cycle after the last stop tick. load may be accepted in that same cycle, which gives back-to-back frames.
- RX FSM IDLE -> STARTCHK -> DATA -> PARITY (if enabled) -> STOP -> (WAITIDLE on framing error) -> IDLE. The receive line is sampled only on bitx8ce.
- IDLE: first tick with line=0 enters STARTCHK.
- STARTCHK: at the 4th tick (mid-bit) the line must still be 0, otherwise return to IDLE with no output (glitch rejection).
- Subsequent samples are taken every 8 ticks, at mid-bit.
- Only the first stop bit is checked; the receiver accepts 1 stop bit regardless of STOPBITS.
- At the stop-bit sample: bytercvd=1 for exactly that clk; q=data, parerr and frmerr (stop sampled 0) updated in the same cycle. parerr=0 when PARITY=0.
- With HASRXBYTEREGISTER=1, q, parerr and frmerr hold until the next bytercvd.
- On frmerr, enter WAITIDLE and re-arm only after a tick samples line=1. A break does not retrigger.
- After a good stop bit, return to IDLE immediately, so a new start is detectable half a bit early.
- loopback change mid-frame: no protection; the frame is undefined, but the FSM must recover to IDLE within one frame time.
- DATABITS=9: d and q are 9 bits. No other width rules apply.

Test Plan:
- Defaults (12 MHz, 115200, 8N1, DIV=13), loopback=1: load d=0x55 -> txbusy high 10*104=1040 clks ±13; single bytercvd, q=0x55, parerr=0, frmerr=0.
- PARITY=1, loopback=0, load d=0x01 -> txpin parity bit=1. Bench drives frame 0x03 with parity bit 1 -> bytercvd, q=0x03, parerr=1.
- Bench drives an 8N1 frame of 0xA5 with stop bit 0, then holds rxpin=0 for 3 frame times -> one bytercvd, q=0xA5, frmerr=1, no further bytercvd until rxpin returns to 1 and a new frame arrives.
- rxpin pulse low for 26 clks (2 ticks) -> no bytercvd. A following valid frame 0x3C is received correctly.
- load 0x11, then load 0x22 while busy, then load 0x33 in the cycle txbusy falls -> txpin carries 0x11 and 0x33 only, back to back.
- rst asserted mid-data during tx and rx -> next cycle txpin=1, txbusy=0, no bytercvd. A subsequent loopback frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_cfg_m.sv
// Full-duplex UART with compile-time width, parity and stop bits.
// The receiver runs from the same 8x oversampling tick that paces the transmitter.
module uart_cfg_m #(
   parameter int unsigned SYSCLKFRQ                = 12000000,
   parameter int unsigned BITCLKFRQ                = 115200,
   parameter int unsigned ACCEPTEDERROR_IN_PERCENT = 2,
   parameter int unsigned DATABITS                 = 8,
   parameter int unsigned PARITY                   = 0,
   parameter int unsigned STOPBITS                 = 1,
   parameter int unsigned HASRXBYTEREGISTER        = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [DATABITS-1:0] d,
   output logic                txpin,
   output logic                txbusy,
   input  logic                rxpin,
   input  logic                loopback,
   output logic                bitx8ce,
   output logic                bytercvd,
   output logic [DATABITS-1:0] q,
   output logic                parerr,
   output logic                frmerr
);

   localparam int unsigned Div      = (SYSCLKFRQ + 4 * BITCLKFRQ) / (8 * BITCLKFRQ);
   localparam int unsigned PrescW   = (Div > 1) ? $clog2(Div) : 1;
   localparam int unsigned ActBaud  = SYSCLKFRQ / (8 * Div);
   localparam int unsigned BaudDiff = (ActBaud > BITCLKFRQ) ? ActBaud - BITCLKFRQ
                                                            : BITCLKFRQ - ActBaud;
   localparam logic        HasPar   = (PARITY != 0);
   localparam logic        OddPar   = (PARITY == 2);
   localparam logic [3:0]  LastData = 4'(DATABITS - 1);
   localparam logic [3:0]  LastStop = 4'(STOPBITS - 1);

   if (BaudDiff * 100 > ACCEPTEDERROR_IN_PERCENT * BITCLKFRQ) begin : g_baud_err
      $error("uart_cfg_m: bit-rate error exceeds ACCEPTEDERROR_IN_PERCENT");
   end
   if (DATABITS < 5 || DATABITS > 9) begin : g_width_err
      $error("uart_cfg_m: DATABITS must be 5..9");
   end

   typedef enum logic [2:0] {TxIdle, TxWait, TxStart, TxData, TxParity, TxStop} tx_state_e;
   typedef enum logic [2:0] {RxIdle, RxStartChk, RxData, RxParity, RxStop, RxWaitIdle} rx_state_e;

   // Free-running prescaler, never resynchronised to frames
   logic [PrescW-1:0] presc_q;

   always_ff @(posedge clk) begin
      if (rst || bitx8ce) presc_q <= '0;
      else                presc_q <= presc_q + PrescW'(1);
   end

   assign bitx8ce = (presc_q == PrescW'(Div - 1));

   // ---------------- transmitter ----------------
   tx_state_e           tx_state_q, tx_state_d;
   logic [2:0]          tx_tick_q;
   logic [3:0]          tx_cnt_q;
   logic [DATABITS-1:0] tx_shift_q;
   logic                tx_par_q;
   logic                tx_bit_end;

   assign tx_bit_end = bitx8ce && (tx_tick_q == 3'd7);

   always_ff @(posedge clk) begin
      if (rst) tx_state_q <= TxIdle;
      else     tx_state_q <= tx_state_d;
   end

   always_comb begin
      tx_state_d = tx_state_q;
      unique case (tx_state_q)
         TxIdle:   if (load) tx_state_d = TxWait;
         TxWait:   if (bitx8ce) tx_state_d = TxStart;
         TxStart:  if (tx_bit_end) tx_state_d = TxData;
         TxData:   if (tx_bit_end && tx_cnt_q == LastData) tx_state_d = HasPar ? TxParity : TxStop;
         TxParity: if (tx_bit_end) tx_state_d = TxStop;
         TxStop:   if (tx_bit_end && tx_cnt_q == LastStop) tx_state_d = TxIdle;
         default:  tx_state_d = TxIdle;
      endcase
   end

   // Tick/bit counters restart on every state change; cnt counts data bits or stop bits
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_tick_q  <= '0;
         tx_cnt_q   <= '0;
         tx_shift_q <= '0;
         tx_par_q   <= 1'b0;
      end else begin
         if (tx_state_q == TxIdle && load) begin
            tx_shift_q <= d;
            tx_par_q   <= ^d ^ OddPar;
         end else if (tx_state_q == TxData && tx_bit_end) begin
            tx_shift_q <= tx_shift_q >> 1;
         end
         if (tx_state_d != tx_state_q) begin
            tx_tick_q <= '0;
            tx_cnt_q  <= '0;
         end else if (bitx8ce) begin
            tx_tick_q <= tx_tick_q + 3'd1;
            if (tx_tick_q == 3'd7) tx_cnt_q <= tx_cnt_q + 4'd1;
         end
      end
   end

   always_comb begin
      txpin  = 1'b1;
      txbusy = (tx_state_q != TxIdle);
      case (tx_state_q)
         TxStart:  txpin = 1'b0;
         TxData:   txpin = tx_shift_q[0];
         TxParity: txpin = tx_par_q;
         default:  txpin = 1'b1;
      endcase
   end

   // ---------------- receiver ----------------
   rx_state_e           rx_state_q, rx_state_d;
   logic [2:0]          rx_tick_q;
   logic [3:0]          rx_cnt_q;
   logic [DATABITS-1:0] rx_shift_q;
   logic                rx_par_q;
   logic                rx_line;
   logic                rx_bit_end;
   logic                rx_done;
   logic                bytercvd_q, parerr_q, frmerr_q;

   always_ff @(posedge clk) begin
      if (rst) rx_state_q <= RxIdle;
      else     rx_state_q <= rx_state_d;
   end

   // Start is confirmed on the third tick after detection, i.e. mid start bit
   always_comb begin
      rx_state_d = rx_state_q;
      unique case (rx_state_q)
         RxIdle:     if (bitx8ce && !rx_line) rx_state_d = RxStartChk;
         RxStartChk: if (bitx8ce && rx_tick_q == 3'd2) rx_state_d = rx_line ? RxIdle : RxData;
         RxData:     if (rx_bit_end && rx_cnt_q == LastData) rx_state_d = HasPar ? RxParity : RxStop;
         RxParity:   if (rx_bit_end) rx_state_d = RxStop;
         RxStop:     if (rx_bit_end) rx_state_d = rx_line ? RxIdle : RxWaitIdle;
         RxWaitIdle: if (bitx8ce && rx_line) rx_state_d = RxIdle;
         default:    rx_state_d = RxIdle;
      endcase
   end

   always_comb begin
      rx_line    = loopback ? txpin : rxpin;
      rx_bit_end = bitx8ce && (rx_tick_q == 3'd7);
      rx_done    = (rx_state_q == RxStop) && rx_bit_end;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_tick_q  <= '0;
         rx_cnt_q   <= '0;
         rx_shift_q <= '0;
         rx_par_q   <= 1'b0;
      end else begin
         if (rx_state_q == RxData && rx_bit_end) rx_shift_q <= {rx_line, rx_shift_q[DATABITS-1:1]};
         if (rx_state_q == RxParity && rx_bit_end) rx_par_q <= rx_line;
         if (rx_state_d != rx_state_q) begin
            rx_tick_q <= '0;
            rx_cnt_q  <= '0;
         end else if (bitx8ce) begin
            rx_tick_q <= rx_tick_q + 3'd1;
            if (rx_tick_q == 3'd7) rx_cnt_q <= rx_cnt_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bytercvd_q <= 1'b0;
         parerr_q   <= 1'b0;
         frmerr_q   <= 1'b0;
      end else begin
         bytercvd_q <= rx_done;
         if (rx_done) begin
            parerr_q <= HasPar & (^rx_shift_q ^ rx_par_q ^ OddPar);
            frmerr_q <= ~rx_line;
         end
      end
   end

   assign bytercvd = bytercvd_q;
   assign parerr   = parerr_q;
   assign frmerr   = frmerr_q;

   if (HASRXBYTEREGISTER != 0) begin : g_qreg
      logic [DATABITS-1:0] q_q;
      always_ff @(posedge clk) begin
         if (rst)          q_q <= '0;
         else if (rx_done) q_q <= rx_shift_q;
      end
      assign q = q_q;
   end else begin : g_qshift
      assign q = rx_shift_q;
   end

endmodule

// File: tb/tb_uart_cfg_m.sv
// Directed bench for uart_cfg_m: default 8N1 instance plus an even-parity instance.
// Bit period is 104 clks (DIV=13); all stimulus and sampling happen on the falling edge.
module tb_uart_cfg_m;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       load = 1'b0, loopback = 1'b0, rxpin = 1'b1;
   logic [7:0] d = 8'h00;
   logic       txpin, txbusy, bitx8ce, bytercvd, parerr, frmerr;
   logic [7:0] q;

   logic       load_p = 1'b0, loopback_p = 1'b0, rxpin_p = 1'b1;
   logic [7:0] d_p = 8'h00;
   logic       txpin_p, txbusy_p, bitx8ce_p, bytercvd_p, parerr_p, frmerr_p;
   logic [7:0] q_p;

   int n_tests = 0;
   int n_fail  = 0;
   int rx_cnt  = 0;
   int rx_cnt_p = 0;

   logic       sniff_en = 1'b0;
   logic [7:0] sniff_b;
   logic [7:0] sniff_q[$];

   uart_cfg_m u_dut (
      .clk(clk), .rst(rst), .load(load), .d(d), .txpin(txpin), .txbusy(txbusy),
      .rxpin(rxpin), .loopback(loopback), .bitx8ce(bitx8ce), .bytercvd(bytercvd),
      .q(q), .parerr(parerr), .frmerr(frmerr)
   );

   uart_cfg_m #(.PARITY(1)) u_dut_p (
      .clk(clk), .rst(rst), .load(load_p), .d(d_p), .txpin(txpin_p), .txbusy(txbusy_p),
      .rxpin(rxpin_p), .loopback(loopback_p), .bitx8ce(bitx8ce_p), .bytercvd(bytercvd_p),
      .q(q_p), .parerr(parerr_p), .frmerr(frmerr_p)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bytercvd)   rx_cnt   <= rx_cnt + 1;
      if (bytercvd_p) rx_cnt_p <= rx_cnt_p + 1;
   end

   // Decodes 8N1 frames on txpin by sampling each bit at its middle
   always begin
      @(negedge clk);
      if (sniff_en && txpin === 1'b0) begin
         repeat (52) @(negedge clk);
         for (int i = 0; i < 8; i++) begin
            repeat (104) @(negedge clk);
            sniff_b[i] = txpin;
         end
         repeat (104) @(negedge clk);
         sniff_q.push_back(sniff_b);
      end
   end

   initial begin
      repeat (100000) @(posedge clk);
      $display("FAIL watchdog: simulation did not finish within 100000 cycles");
      $fatal(1);
   end

   task automatic send_load(input logic [7:0] v);
      d    = v;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   // bits are LSB first: start, data, [parity], stop
   task automatic drive_frame(input bit to_par, input logic [10:0] bits, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         if (to_par) rxpin_p = bits[i];
         else        rxpin   = bits[i];
         repeat (104) @(negedge clk);
      end
   endtask

   task automatic wait_tx_idle(input string name);
      int cyc;
      cyc = 0;
      while (txbusy && cyc < 2000) begin
         cyc++;
         @(negedge clk);
      end
      n_tests++;
      if (txbusy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_timeout: txbusy got %b want 0 after %0d cycles", name, txbusy, cyc);
      end
   endtask

   task automatic test_reset();
      int cyc;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({txpin, txbusy, bitx8ce, bytercvd, parerr, frmerr, q} !== {1'b1, 5'b0, 8'h00}) begin
         n_fail++;
         $display("FAIL reset_main: got %b want %b",
                  {txpin, txbusy, bitx8ce, bytercvd, parerr, frmerr, q}, {1'b1, 5'b0, 8'h00});
      end
      n_tests++;
      if ({txpin_p, txbusy_p, bitx8ce_p, bytercvd_p, parerr_p, frmerr_p, q_p}
          !== {1'b1, 5'b0, 8'h00}) begin
         n_fail++;
         $display("FAIL reset_par: got %b want %b",
                  {txpin_p, txbusy_p, bitx8ce_p, bytercvd_p, parerr_p, frmerr_p, q_p},
                  {1'b1, 5'b0, 8'h00});
      end
      rst = 1'b0;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!bitx8ce && cyc < 40);
      n_tests++;
      if (cyc !== 12) begin
         n_fail++;
         $display("FAIL first_tick: got %0d cycles want 12", cyc);
      end
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!bitx8ce && cyc < 40);
      n_tests++;
      if (cyc !== 13) begin
         n_fail++;
         $display("FAIL tick_period: got %0d cycles want 13", cyc);
      end
   endtask

   task automatic test_loopback();
      int cyc, r0;
      loopback = 1'b1;
      r0 = rx_cnt;
      send_load(8'h55);
      cyc = 0;
      while (txbusy && cyc < 2000) begin
         cyc++;
         @(negedge clk);
      end
      n_tests++;
      if (cyc < 1027 || cyc > 1053) begin
         n_fail++;
         $display("FAIL busy_len: got %0d cycles want 1027..1053", cyc);
      end
      repeat (5) @(negedge clk);
      n_tests++;
      if (rx_cnt !== r0 + 1) begin
         n_fail++;
         $display("FAIL loop_count: got %0d want %0d", rx_cnt, r0 + 1);
      end
      n_tests++;
      if ({q, parerr, frmerr} !== {8'h55, 2'b00}) begin
         n_fail++;
         $display("FAIL loop_data: got %h/%b%b want 55/00", q, parerr, frmerr);
      end
      loopback = 1'b0;
   endtask

   task automatic test_parity();
      int cyc, r0;
      d_p    = 8'h01;
      load_p = 1'b1;
      @(negedge clk);
      load_p = 1'b0;
      cyc = 0;
      while (txpin_p !== 1'b0 && cyc < 200) begin
         cyc++;
         @(negedge clk);
      end
      repeat (52 + 104) @(negedge clk);
      n_tests++;
      if (txpin_p !== 1'b1) begin
         n_fail++;
         $display("FAIL par_tx_bit0: got %b want 1", txpin_p);
      end
      repeat (104) @(negedge clk);
      n_tests++;
      if (txpin_p !== 1'b0) begin
         n_fail++;
         $display("FAIL par_tx_bit1: got %b want 0", txpin_p);
      end
      repeat (104 * 7) @(negedge clk);
      n_tests++;
      if (txpin_p !== 1'b1) begin
         n_fail++;
         $display("FAIL par_tx_parity: got %b want 1", txpin_p);
      end
      repeat (300) @(negedge clk);
      r0 = rx_cnt_p;
      drive_frame(1'b1, {1'b1, 1'b1, 8'h03, 1'b0}, 11);
      repeat (10) @(negedge clk);
      n_tests++;
      if ({rx_cnt_p == r0 + 1, q_p, parerr_p, frmerr_p} !== {1'b1, 8'h03, 2'b10}) begin
         n_fail++;
         $display("FAIL par_rx_bad: got cnt+%0d %h/%b%b want cnt+1 03/10",
                  rx_cnt_p - r0, q_p, parerr_p, frmerr_p);
      end
      drive_frame(1'b1, {1'b1, 1'b0, 8'h03, 1'b0}, 11);
      repeat (10) @(negedge clk);
      n_tests++;
      if ({rx_cnt_p == r0 + 2, q_p, parerr_p, frmerr_p} !== {1'b1, 8'h03, 2'b00}) begin
         n_fail++;
         $display("FAIL par_rx_good: got cnt+%0d %h/%b%b want cnt+2 03/00",
                  rx_cnt_p - r0, q_p, parerr_p, frmerr_p);
      end
   endtask

   task automatic test_framing();
      int r0;
      r0 = rx_cnt;
      drive_frame(1'b0, {1'b0, 8'hA5, 1'b0}, 10);
      rxpin = 1'b0;
      repeat (3 * 1040) @(negedge clk);
      n_tests++;
      if ({rx_cnt == r0 + 1, q, frmerr} !== {1'b1, 8'hA5, 1'b1}) begin
         n_fail++;
         $display("FAIL frm_err: got cnt+%0d %h/%b want cnt+1 a5/1", rx_cnt - r0, q, frmerr);
      end
      rxpin = 1'b1;
      repeat (300) @(negedge clk);
      n_tests++;
      if (rx_cnt !== r0 + 1) begin
         n_fail++;
         $display("FAIL frm_break: got cnt+%0d want cnt+1", rx_cnt - r0);
      end
      drive_frame(1'b0, {1'b1, 8'h5A, 1'b0}, 10);
      repeat (10) @(negedge clk);
      n_tests++;
      if ({rx_cnt == r0 + 2, q, frmerr} !== {1'b1, 8'h5A, 1'b0}) begin
         n_fail++;
         $display("FAIL frm_recover: got cnt+%0d %h/%b want cnt+2 5a/0", rx_cnt - r0, q, frmerr);
      end
   endtask

   task automatic test_glitch();
      int r0;
      r0 = rx_cnt;
      rxpin = 1'b0;
      repeat (26) @(negedge clk);
      rxpin = 1'b1;
      repeat (300) @(negedge clk);
      n_tests++;
      if (rx_cnt !== r0) begin
         n_fail++;
         $display("FAIL glitch_reject: got cnt+%0d want cnt+0", rx_cnt - r0);
      end
      drive_frame(1'b0, {1'b1, 8'h3C, 1'b0}, 10);
      repeat (10) @(negedge clk);
      n_tests++;
      if ({rx_cnt == r0 + 1, q, frmerr} !== {1'b1, 8'h3C, 1'b0}) begin
         n_fail++;
         $display("FAIL glitch_next: got cnt+%0d %h/%b want cnt+1 3c/0", rx_cnt - r0, q, frmerr);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] f0, f1;
      sniff_q.delete();
      sniff_en = 1'b1;
      send_load(8'h11);
      repeat (300) @(negedge clk);
      send_load(8'h22);
      wait_tx_idle("b2b_first");
      send_load(8'h33);
      n_tests++;
      if (txbusy !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_accept: txbusy got %b want 1", txbusy);
      end
      wait_tx_idle("b2b_second");
      repeat (60) @(negedge clk);
      sniff_en = 1'b0;
      f0 = 8'hxx;
      f1 = 8'hxx;
      if (sniff_q.size() > 0) f0 = sniff_q[0];
      if (sniff_q.size() > 1) f1 = sniff_q[1];
      n_tests++;
      if (sniff_q.size() !== 2) begin
         n_fail++;
         $display("FAIL b2b_frames: got %0d frames want 2", sniff_q.size());
      end
      n_tests++;
      if ({f0, f1} !== {8'h11, 8'h33}) begin
         n_fail++;
         $display("FAIL b2b_data: got %h %h want 11 33", f0, f1);
      end
   endtask

   task automatic test_reset_mid();
      int r0;
      loopback = 1'b1;
      r0 = rx_cnt;
      send_load(8'h0F);
      repeat (450) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({txpin, txbusy, bytercvd, q} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
         n_fail++;
         $display("FAIL rst_mid: got %b want %b", {txpin, txbusy, bytercvd, q},
                  {1'b1, 1'b0, 1'b0, 8'h00});
      end
      rst = 1'b0;
      repeat (1200) @(negedge clk);
      n_tests++;
      if (rx_cnt !== r0) begin
         n_fail++;
         $display("FAIL rst_no_rx: got cnt+%0d want cnt+0", rx_cnt - r0);
      end
      send_load(8'h7E);
      wait_tx_idle("rst_next");
      repeat (5) @(negedge clk);
      n_tests++;
      if ({rx_cnt == r0 + 1, q, frmerr} !== {1'b1, 8'h7E, 1'b0}) begin
         n_fail++;
         $display("FAIL rst_next_rx: got cnt+%0d %h/%b want cnt+1 7e/0", rx_cnt - r0, q, frmerr);
      end
      loopback = 1'b0;
   endtask

   initial begin
      test_reset();
      test_loopback();
      test_parity();
      test_framing();
      test_glitch();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
